// File: rtl/fewcore_pkg.sv
// fewcore_pkg: opcode/funct3 constants and FSM states shared by the mem_access stage
package fewcore_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/mem_access_load_align.sv
// load_align: left-justifies the loaded byte/half/word (ram_rdata, funct3, offset -> word)
module load_align
  import fewcore_pkg::*;
(
  input  logic [31:0] ram_rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] word
);
  logic [7:0] b;
  assign b = 8'(ram_rdata >> {offset, 3'b000});
  assign word = (funct3 == F3_B || funct3 == F3_BU) ? {b, 24'b0} :
                (funct3 == F3_H || funct3 == F3_HU) ? {offset[1] ? ram_rdata[31:16] : ram_rdata[15:0], 16'b0} :
                ram_rdata;
endmodule

// File: rtl/mem_access.sv
// mem_access: load/store stage (clk, reset, operation/req_valid/req_ready/address/content_rs2 in, memData/rsp_valid/stall out, ram_* word RAM port, misalign only with MEM_MISALIGN_TRAP_EN)
module mem_access
  import fewcore_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       operation,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   address,
  input  logic [XLEN-1:0]   content_rs2,
  output logic [31:0]       memData,
  output logic              rsp_valid,
  output logic              stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack
);
  state_t state;
  logic [2:0] f3, f3_q;
  logic [1:0] off_q;
  logic is_ld, is_st, legal, mis;
  logic [3:0] st_be;
  logic [31:0] st_wdata, ld_word;
  logic unused_bits;
  assign unused_bits = ^{operation[11:10], address[XLEN-1:RAM_AW+2]};
  assign f3 = operation[9:7];
  assign is_ld = operation[6:0] == OP_LOAD;
  assign is_st = operation[6:0] == OP_STORE;
  assign legal = is_ld ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) : (f3 inside {F3_B, F3_H, F3_W});
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = legal && ((f3 == F3_H || f3 == F3_HU) ? address[0] : (f3 == F3_W) ? |address[1:0] : 1'b0);
`else
  assign mis = 1'b0;
`endif
  assign st_be = (f3 == F3_B) ? 4'b0001 << address[1:0] : (f3 == F3_H) ? (address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_wdata = (f3 == F3_B) ? {4{content_rs2[7:0]}} : (f3 == F3_H) ? {2{content_rs2[15:0]}} : content_rs2[31:0];
  assign req_ready = state == IDLE;
  assign stall = state != IDLE;
  load_align u_align (
    .ram_rdata(ram_rdata),
    .funct3   (f3_q),
    .offset   (off_q),
    .word     (ld_word)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      memData <= '0;
      rsp_valid <= 1'b0;
      ram_req <= 1'b0;
      ram_we <= 1'b0;
      ram_be <= '0;
      ram_addr <= '0;
      ram_wdata <= '0;
      f3_q <= '0;
      off_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid && (is_ld || is_st)) begin
          if (!legal || mis) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            memData <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign <= mis;
`endif
          end else begin
            state <= ACCESS;
            ram_req <= 1'b1;
            ram_we <= is_st;
            ram_be <= is_st ? st_be : 4'b1111;
            ram_addr <= address[RAM_AW+1:2];
            ram_wdata <= st_wdata;
            f3_q <= f3;
            off_q <= address[1:0];
          end
        end
        ACCESS: if (ram_ack) begin
          state <= RESP;
          ram_req <= 1'b0;
          rsp_valid <= 1'b1;
          if (!ram_we) memData <= ld_word;
        end
        RESP: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed plus random load/store transactions checked against a behavioural model
module tb_mem_access;
  logic clk = 1'b0;
  logic reset;
  logic [11:0] operation;
  logic req_valid, req_ready;
  logic [31:0] address, content_rs2, memData, ram_wdata, ram_rdata;
  logic rsp_valid, stall, ram_req, ram_we, ram_ack;
  logic [3:0] ram_be;
  logic [9:0] ram_addr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
`endif
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mem_exp = 0;
  always #5 clk = ~clk;
  mem_access dut (
    .clk(clk), .reset(reset), .operation(operation), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .content_rs2(content_rs2), .memData(memData), .rsp_valid(rsp_valid),
    .stall(stall), .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int o = int'(a % 4);
    if (f3 == 0 || f3 == 4) return ((w >> (8 * o)) & 32'hFF) << 24;
    if (f3 == 1 || f3 == 5) return ((w >> (16 * (o / 2))) & 32'hFFFF) << 16;
    return w;
  endfunction
  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int o = int'(a % 4);
    if (f3 == 0) return 4'(1 << o);
    if (f3 == 1) return 4'(3 << (2 * (o / 2)));
    return 4'hF;
  endfunction
  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction
  task automatic do_txn(input logic [11:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int waits);
    logic [2:0] f3 = op[9:7];
    logic ld = op[6:0] == 7'b0000011;
    logic st = op[6:0] == 7'b0100011;
    logic legal = ld ? (f3 != 3 && f3 != 6 && f3 != 7) : (f3 < 3);
    logic mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = legal && (((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr[1:0] != 0));
`endif
    chk("ready_idle", req_ready, 1);
    req_valid = 1; operation = op; address = addr; content_rs2 = rs2;
    @(negedge clk);
    req_valid = 0; operation = 12'($urandom); address = $urandom; content_rs2 = $urandom;
    if (!(ld || st)) begin
      chk("ignored_stall", stall, 0);
      chk("ignored_rsp", rsp_valid, 0);
      chk("ignored_req", ram_req, 0);
      return;
    end
    if (!legal || mis) begin
      mem_exp = 0;
      chk("trap_no_req", ram_req, 0);
      chk("trap_rsp", rsp_valid, 1);
      chk("trap_data", memData, mem_exp);
      chk("trap_ready", req_ready, 0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("trap_misalign", misalign, mis);
`endif
    end else begin
      chk("acc_req", ram_req, 1);
      chk("acc_rsp", rsp_valid, 0);
      chk("acc_stall", stall, 1);
      chk("acc_we", ram_we, st);
      chk("acc_be", ram_be, st ? exp_be(f3, addr) : 4'hF);
      chk("acc_addr", ram_addr, (addr >> 2) & 32'h3FF);
      if (st) chk("acc_wdata", ram_wdata, exp_wdata(f3, rs2));
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        chk("wait_req", ram_req, 1);
        chk("wait_stall", stall, 1);
        chk("wait_rsp", rsp_valid, 0);
      end
      ram_ack = 1; ram_rdata = rdata;
      @(negedge clk);
      ram_ack = 0; ram_rdata = $urandom;
      if (ld) mem_exp = exp_load(f3, addr, rdata);
      chk("resp_rsp", rsp_valid, 1);
      chk("resp_req", ram_req, 0);
      chk("resp_ready", req_ready, 0);
      chk("resp_stall", stall, 1);
      chk("resp_data", memData, mem_exp);
    end
    @(negedge clk);
    chk("end_rsp", rsp_valid, 0);
    chk("end_stall", stall, 0);
    chk("end_data", memData, mem_exp);
  endtask
  initial begin
    reset = 1; req_valid = 0; operation = 0; address = 0; content_rs2 = 0; ram_rdata = 0; ram_ack = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_data", memData, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req", ram_req, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_be", ram_be, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_ready", req_ready, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_misalign", misalign, 0);
`endif
    do_txn({2'b0, 3'b010, 7'b0000011}, 32'h10, 0, 32'hDEADBEEF, 3);
    do_txn({2'b0, 3'b000, 7'b0000011}, 32'h13, 0, 32'h80AB11CC, 1);
    do_txn({2'b0, 3'b101, 7'b0000011}, 32'h12, 0, 32'h80AB11CC, 0);
    do_txn({2'b0, 3'b000, 7'b0100011}, 32'h21, 32'h000000A5, 32'h0, 2);
    do_txn({2'b0, 3'b010, 7'b0100011}, 32'h40, 32'h12345678, 32'h0, 0);
    do_txn({2'b0, 3'b010, 7'b0000011}, 32'h40, 0, 32'h12345678, 0);
    do_txn({2'b0, 3'b010, 7'b0000011}, 32'h02, 0, 32'hCAFEF00D, 0);
    do_txn({2'b0, 3'b011, 7'b0000011}, 32'h08, 0, 32'h0, 0);
    do_txn({2'b0, 3'b000, 7'b0110011}, 32'h08, 0, 32'h0, 0);
    req_valid = 1; operation = {2'b0, 3'b010, 7'b0000011}; address = 32'h8;
    @(negedge clk);
    req_valid = 0;
    chk("mid_req", ram_req, 1);
    reset = 1;
    @(negedge clk);
    reset = 0; ram_ack = 1; ram_rdata = 32'h55AA55AA;
    mem_exp = 0;
    chk("mid_rst_req", ram_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_be", ram_be, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_data", memData, mem_exp);
    @(negedge clk);
    ram_ack = 0;
    chk("late_ack_rsp", rsp_valid, 0);
    chk("late_ack_req", ram_req, 0);
    chk("late_ack_stall", stall, 0);
    for (int t = 0; t < 40; t++) begin
      int kind = int'($urandom_range(0, 9));
      logic [6:0] opc = kind == 0 ? 7'b0110011 : kind < 5 ? 7'b0000011 : 7'b0100011;
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      do_txn({2'($urandom), f3, opc}, $urandom & 32'hFFF, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
